filter_path_scheduler: RTL

- Frame-level sequencer for the audio filter datapath. It generates the ADC/DAC sync pulses and the filter sink strobe.
- It collects the low-pass and high-pass FIR outputs, selects or mixes them per a mode input, and presents one 12-bit sample per frame to the DAC packager.
- It replaces the standalone sync generator and is the single owner of frame timing between ADC, filters and DAC.

---
 rtl/filter_path_scheduler_pkg.sv | 20 ++
 rtl/filter_path_scheduler_sample_mixer.sv | 39 +++
 rtl/filter_path_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/filter_path_scheduler_pkg.sv
// filter_path_scheduler shared types: mode encodings, FSM states, FIR codes.
// Optional FILTER_SUM_SAT_EN selects saturating sum in sample_mixer.
package filter_path_scheduler_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_LOW    = 2'b01;
  localparam logic [1:0] MODE_HIGH   = 2'b10;
  localparam logic [1:0] MODE_SUM    = 2'b11;

  localparam logic [1:0] ERR_OK = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CAPTURE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/filter_path_scheduler_sample_mixer.sv
// Combinational select / average / saturate of the frame's output sample.
// FILTER_SUM_SAT_EN: mode 11 saturates low+high instead of halving.
module sample_mixer #(
  parameter int DATA_W = 12
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] adc,
  input  logic [DATA_W-1:0] low,
  input  logic [DATA_W-1:0] high,
  output logic [DATA_W-1:0] mix
);
  import filter_path_scheduler_pkg::*;

  logic signed [DATA_W:0] sum;

  assign sum = $signed({low[DATA_W-1], low})
             + $signed({high[DATA_W-1], high});

  always_comb begin
    mix = adc;
    unique case (mode)
      MODE_LOW:  mix = low;
      MODE_HIGH: mix = high;
      MODE_SUM: begin
`ifdef FILTER_SUM_SAT_EN
        // sign bits disagree only on overflow
        if (sum[DATA_W] != sum[DATA_W-1])
          mix = {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}};
        else
          mix = sum[DATA_W-1:0];
`else
        mix = sum[DATA_W:1];
`endif
      end
      default: mix = adc;
    endcase
  end

endmodule

// File: rtl/filter_path_scheduler.sv
// Frame sequencer: ADC/DAC sync, filter strobe, result collection, DAC sample.
// FILTER_SUM_SAT_EN (optional) switches mode 11 to a saturating sum.
module filter_path_scheduler #(
  parameter int FRAME_LEN    = 16,
  parameter int CAPTURE_SLOT = 14,
  parameter int DATA_W       = 12
) (
  input  logic              dacSerialClock,
  input  logic              resetN,
  input  logic              enable,
  input  logic [1:0]        modeSel,
  input  logic [DATA_W-1:0] adcSample,
  input  logic [DATA_W-1:0] lowPassData,
  input  logic              lowPassValid,
  input  logic [1:0]        lowPassError,
  input  logic [DATA_W-1:0] highPassData,
  input  logic              highPassValid,
  input  logic [1:0]        highPassError,
  output logic              syncADC,
  output logic              syncDAC,
  output logic              sinkValid,
  output logic [DATA_W-1:0] filterSinkData,
  output logic [DATA_W-1:0] dacSample,
  output logic              dacSampleValid,
  output logic [1:0]        activeMode,
  output logic              timeoutFlag
);
  import filter_path_scheduler_pkg::*;

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] SLOT = CW'(CAPTURE_SLOT);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              got_lo_q, got_lo_d;
  logic              got_hi_q, got_hi_d;
  logic [DATA_W-1:0] lp_q, lp_d;
  logic [DATA_W-1:0] hp_q, hp_d;
  logic [DATA_W-1:0] fsd_q, fsd_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              dval_q, dval_d;
  logic              tmo_q, tmo_d;
  logic [DATA_W-1:0] mix;
  logic              lp_ok, hp_ok, last;
  logic              complete, tmo_now;

  assign lp_ok = lowPassValid && (lowPassError == ERR_OK);
  assign hp_ok = highPassValid && (highPassError == ERR_OK);
  assign last  = (cnt_q == LAST);

  // results are collected from SYNC through WAIT; SYNC restarts the set
  always_comb begin
    got_lo_d = got_lo_q;
    got_hi_d = got_hi_q;
    lp_d     = lp_q;
    hp_d     = hp_q;
    if (enable && (state_q == SYNC || state_q == CAPTURE ||
                   state_q == WAIT)) begin
      if (state_q == SYNC) begin
        got_lo_d = 1'b0;
        got_hi_d = 1'b0;
      end
      if (lp_ok) begin
        got_lo_d = 1'b1;
        lp_d     = lowPassData;
      end
      if (hp_ok) begin
        got_hi_d = 1'b1;
        hp_d     = highPassData;
      end
    end
  end

  always_comb begin
    complete = 1'b0;
    unique case (mode_q)
      MODE_LOW:  complete = got_lo_d;
      MODE_HIGH: complete = got_hi_d;
      MODE_SUM:  complete = got_lo_d && got_hi_d;
      default:   complete = 1'b0;
    endcase
  end

  assign tmo_now = enable && (state_q == WAIT) && last && !complete;

  sample_mixer #(.DATA_W(DATA_W)) u_mixer (
    .mode (mode_q),
    .adc  (adcSample),
    .low  (lp_d),
    .high (hp_d),
    .mix  (mix)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fsd_d   = fsd_q;
    dac_d   = dac_q;
    dval_d  = 1'b0;
    tmo_d   = tmo_q | tmo_now;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
        SYNC: begin
          mode_d  = modeSel;
          state_d = CAPTURE;
        end
        CAPTURE: begin
          if (cnt_q == SLOT) begin
            fsd_d = adcSample;
            if (mode_q == MODE_BYPASS) begin
              dac_d   = mix;
              dval_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (complete) begin
            dac_d   = mix;
            dval_d  = 1'b1;
            state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
      if (last && state_q != IDLE) state_d = SYNC;
    end
  end

  always_ff @(posedge dacSerialClock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= MODE_BYPASS;
      got_lo_q <= 1'b0;
      got_hi_q <= 1'b0;
      lp_q     <= '0;
      hp_q     <= '0;
      fsd_q    <= '0;
      dac_q    <= '0;
      dval_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      got_lo_q <= got_lo_d;
      got_hi_q <= got_hi_d;
      lp_q     <= lp_d;
      hp_q     <= hp_d;
      fsd_q    <= fsd_d;
      dac_q    <= dac_d;
      dval_q   <= dval_d;
      tmo_q    <= tmo_d;
    end
  end

  assign syncADC        = enable && (state_q == SYNC);
  assign syncDAC        = syncADC;
  assign sinkValid      = enable && (state_q == CAPTURE) && (cnt_q == SLOT);
  assign filterSinkData = fsd_q;
  assign dacSample      = dac_q;
  assign dacSampleValid = dval_q;
  assign activeMode     = mode_q;
  assign timeoutFlag    = tmo_q | tmo_now;

endmodule
